// File: rtl/wt_mem_responder_if.sv
// Request/return bus between a write-through cache and its memory-side responder.
// The master modport is the cache side; the slave modport is the responder.
interface wt_mem_responder_if #(
   parameter int TidWidth = 2
);
   logic                data_req_i;
   logic                data_ack_o;
   logic [1:0]          data_type_i;
   logic [63:0]         data_paddr_i;
   logic [63:0]         data_wdata_i;
   logic [7:0]          data_be_i;
   logic [TidWidth-1:0] data_tid_i;
   logic                rtrn_vld_o;
   logic [1:0]          rtrn_type_o;
   logic [TidWidth-1:0] rtrn_tid_o;
   logic [63:0]         rtrn_data_o;
   logic                busy_o;

   modport master (
      output data_req_i, data_type_i, data_paddr_i, data_wdata_i, data_be_i, data_tid_i,
      input  data_ack_o, rtrn_vld_o, rtrn_type_o, rtrn_tid_o, rtrn_data_o, busy_o
   );

   modport slave (
      input  data_req_i, data_type_i, data_paddr_i, data_wdata_i, data_be_i, data_tid_i,
      output data_ack_o, rtrn_vld_o, rtrn_type_o, rtrn_tid_o, rtrn_data_o, busy_o
   );
endinterface

// File: rtl/wt_mem_responder.sv
// Memory-side responder for the write-through cache request/return interface.
// Requests are serviced from an internal word memory at accept time; the result
// waits in an in-order FIFO and is returned a fixed number of cycles later.
module wt_mem_responder #(
   parameter int MemWords  = 256,
   parameter int FifoDepth = 4,
   parameter int Latency   = 3,
   parameter int TidWidth  = 2
) (
   input logic               clk_i,
   input logic               rst_ni,
   wt_mem_responder_if.slave bus
);
   localparam int IdxW = (MemWords > 1) ? $clog2(MemWords) : 1;
   localparam int PtrW = (FifoDepth > 1) ? $clog2(FifoDepth) : 1;
   localparam int CntW = $clog2(FifoDepth) + 1;
   // The ack cycle already counts as one step of the countdown, so the value
   // held in the entry after the ack edge is one below Latency-1.
   localparam logic [3:0] CntInit = (Latency >= 2) ? 4'(Latency - 2) : 4'd0;
   // With a one-cycle latency the accepted request goes straight to the return
   // register and never occupies the FIFO.
   localparam bit Bypass = (Latency == 1);

   localparam logic [1:0] TypeStore = 2'd2;
   localparam logic [1:0] TypeRsvd  = 2'd3;

   typedef struct packed {
      logic [1:0]          typ;
      logic [TidWidth-1:0] tid;
      logic [63:0]         data;
   } ent_t;

   logic [63:0]    mem_q [MemWords];
   ent_t           ent_q [FifoDepth];
   logic [3:0]     cnt_q [FifoDepth];
   logic [FifoDepth-1:0] vld_q;
   logic [PtrW-1:0] rd_ptr_q, wr_ptr_q;
   logic [CntW-1:0] count_q;
   ent_t           rtrn_q;
   logic           rtrn_vld_q;

   logic [IdxW-1:0] idx;
   logic            ack, push, pop, is_store;
   ent_t            in_ent;
   logic            unused_bits;

   function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
      return (p == PtrW'(FifoDepth - 1)) ? '0 : p + 1'b1;
   endfunction

   assign idx         = bus.data_paddr_i[3 +: IdxW];
   assign unused_bits = ^{bus.data_paddr_i[63:3+IdxW], bus.data_paddr_i[2:0]};
   assign is_store    = (bus.data_type_i == TypeStore);

   // Full check looks only at the registered count: a pop this cycle does not
   // open a slot for an accept in the same cycle.
   assign ack  = bus.data_req_i & (count_q != CntW'(FifoDepth)) & (bus.data_type_i != TypeRsvd);
   assign push = ack & ~Bypass;
   assign pop  = (count_q != '0) & (cnt_q[rd_ptr_q] == 4'd0);

   assign in_ent.typ  = bus.data_type_i;
   assign in_ent.tid  = bus.data_tid_i;
   assign in_ent.data = is_store ? 64'd0 : mem_q[idx];

   // Backing memory: cleared on reset, byte-merged store on accept.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         for (int i = 0; i < MemWords; i++) mem_q[i] <= '0;
      end else if (ack && is_store) begin
         for (int b = 0; b < 8; b++)
            if (bus.data_be_i[b]) mem_q[idx][8*b +: 8] <= bus.data_wdata_i[8*b +: 8];
      end
   end

   // In-order FIFO of accepted requests with per-entry countdowns.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         vld_q    <= '0;
         rd_ptr_q <= '0;
         wr_ptr_q <= '0;
         count_q  <= '0;
         for (int i = 0; i < FifoDepth; i++) begin
            ent_q[i] <= '0;
            cnt_q[i] <= '0;
         end
      end else begin
         for (int i = 0; i < FifoDepth; i++)
            if (vld_q[i] && cnt_q[i] != 4'd0) cnt_q[i] <= cnt_q[i] - 4'd1;
         if (push) begin
            ent_q[wr_ptr_q] <= in_ent;
            cnt_q[wr_ptr_q] <= CntInit;
            vld_q[wr_ptr_q] <= 1'b1;
            wr_ptr_q        <= ptr_inc(wr_ptr_q);
         end
         if (pop) begin
            vld_q[rd_ptr_q] <= 1'b0;
            rd_ptr_q        <= ptr_inc(rd_ptr_q);
         end
         case ({push, pop})
            2'b10:   count_q <= count_q + 1'b1;
            2'b01:   count_q <= count_q - 1'b1;
            default: count_q <= count_q;
         endcase
      end
   end

   // Return register: one cycle pulse carrying the popped head, zeros otherwise.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         rtrn_vld_q <= 1'b0;
         rtrn_q     <= '0;
      end else if (pop) begin
         rtrn_vld_q <= 1'b1;
         rtrn_q     <= ent_q[rd_ptr_q];
      end else if (Bypass && ack) begin
         rtrn_vld_q <= 1'b1;
         rtrn_q     <= in_ent;
      end else begin
         rtrn_vld_q <= 1'b0;
         rtrn_q     <= '0;
      end
   end

   assign bus.data_ack_o  = ack;
   assign bus.rtrn_vld_o  = rtrn_vld_q;
   assign bus.rtrn_type_o = rtrn_q.typ;
   assign bus.rtrn_tid_o  = rtrn_q.tid;
   assign bus.rtrn_data_o = rtrn_q.data;
   assign bus.busy_o      = (count_q != '0) | rtrn_vld_q;
endmodule

// File: tb/tb_wt_mem_responder.sv
// Bench for wt_mem_responder: directed table, random traffic against a
// return-schedule model, mid-operation reset, and a full-FIFO sequence on a
// second, deeper-latency instance.
module tb_wt_mem_responder;
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   wt_mem_responder_if #(.TidWidth(2)) bus ();
   wt_mem_responder_if #(.TidWidth(2)) bf ();

   wt_mem_responder #(.MemWords(256), .FifoDepth(4), .Latency(3), .TidWidth(2)) dut (
      .clk_i(clk), .rst_ni(rst_n), .bus(bus));
   wt_mem_responder #(.MemWords(4), .FifoDepth(2), .Latency(4), .TidWidth(2)) dut_full (
      .clk_i(clk), .rst_ni(rst_n), .bus(bf));

   int checks = 0;
   int fails  = 0;
   int cyc    = 0;

   // Model: memory image plus a queue of scheduled returns.
   typedef struct {
      int          ret;
      logic [1:0]  typ;
      logic [1:0]  tid;
      logic [63:0] data;
   } exp_t;
   logic [63:0] mem_m [256];
   exp_t        q [$];
   int          last_ret;

   logic        a_ack, a_vld, a_busy;
   logic [1:0]  a_typ, a_tid;
   logic [63:0] a_data;

   typedef struct {
      logic        req;
      logic [1:0]  typ;
      logic [63:0] paddr;
      logic [63:0] wdata;
      logic [7:0]  be;
      logic [1:0]  tid;
      logic        ack;
      logic        vld;
      logic [1:0]  rtyp;
      logic [1:0]  rtid;
      logic [63:0] rdata;
      logic        busy;
   } vec_t;
   vec_t tbl [$];

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s cyc=%0d got=%h exp=%h", nm, cyc, act, exp);
      end
   endtask

   task automatic model_reset();
      for (int i = 0; i < 256; i++) mem_m[i] = '0;
      q.delete();
      last_ret = -100;
   endtask

   // One cycle on the main DUT: drive, sample mid-cycle, compare to model, advance.
   task automatic step(input logic req, input logic [1:0] typ, input logic [63:0] paddr,
                       input logic [63:0] wdata, input logic [7:0] be, input logic [1:0] tid);
      int   cnt_m, ret, idx;
      logic e_ack, e_vld;
      exp_t e;
      bus.data_req_i   = req;
      bus.data_type_i  = typ;
      bus.data_paddr_i = paddr;
      bus.data_wdata_i = wdata;
      bus.data_be_i    = be;
      bus.data_tid_i   = tid;
      @(negedge clk);
      cnt_m = 0;
      foreach (q[i]) if (q[i].ret > cyc) cnt_m++;
      e_ack = req && (typ != 2'd3) && (cnt_m < 4);
      e_vld = (q.size() > 0) && (q[0].ret == cyc);
      e = '{0, 2'd0, 2'd0, 64'd0};
      if (e_vld) e = q.pop_front();
      a_ack  = bus.data_ack_o;
      a_vld  = bus.rtrn_vld_o;
      a_typ  = bus.rtrn_type_o;
      a_tid  = bus.rtrn_tid_o;
      a_data = bus.rtrn_data_o;
      a_busy = bus.busy_o;
      chk("ack", a_ack, e_ack);
      chk("rtrn_vld", a_vld, e_vld);
      chk("rtrn_type", a_typ, e.typ);
      chk("rtrn_tid", a_tid, e.tid);
      chk("rtrn_data", a_data, e.data);
      chk("busy", a_busy, (cnt_m != 0) || e_vld);
      if (e_ack) begin
         idx = int'(paddr[10:3]);
         ret = (cyc + 3 > last_ret + 1) ? cyc + 3 : last_ret + 1;
         q.push_back('{ret, typ, tid, (typ == 2'd2) ? 64'd0 : mem_m[idx]});
         last_ret = ret;
         if (typ == 2'd2)
            for (int b = 0; b < 8; b++) if (be[b]) mem_m[idx][8*b +: 8] = wdata[8*b +: 8];
      end
      @(posedge clk);
      #1;
      cyc++;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step(1'b0, 2'd0, 64'd0, 64'd0, 8'd0, 2'd0);
   endtask

   task automatic chk_zero_out(input string nm);
      chk({nm, "_vld"}, bus.rtrn_vld_o, 0);
      chk({nm, "_type"}, bus.rtrn_type_o, 0);
      chk({nm, "_tid"}, bus.rtrn_tid_o, 0);
      chk({nm, "_data"}, bus.rtrn_data_o, 0);
      chk({nm, "_busy"}, bus.busy_o, 0);
   endtask

   // Reset pulse of one cycle starting just after a rising edge.
   task automatic do_reset();
      bus.data_req_i = 1'b0;
      rst_n = 1'b0;
      #1;
      chk_zero_out("async_rst");
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      model_reset();
      cyc++;
   endtask

   function automatic vec_t v(input logic req, input logic [1:0] typ, input logic [63:0] paddr,
                              input logic [63:0] wdata, input logic [7:0] be, input logic [1:0] tid,
                              input logic ack, input logic vld, input logic [1:0] rtyp,
                              input logic [1:0] rtid, input logic [63:0] rdata, input logic busy);
      vec_t r;
      r = '{req, typ, paddr, wdata, be, tid, ack, vld, rtyp, rtid, rdata, busy};
      return r;
   endfunction

   function automatic vec_t vi(input logic vld, input logic [1:0] rtyp, input logic [1:0] rtid,
                               input logic [63:0] rdata, input logic busy);
      return v(1'b0, 2'd0, 64'd0, 64'd0, 8'd0, 2'd0, 1'b0, vld, rtyp, rtid, rdata, busy);
   endfunction

   initial begin
      logic [63:0] pa, wd;
      logic        f_req [10];
      logic        f_ack [10];
      logic        f_vld [10];
      logic [1:0]  f_tid [10];
      logic [1:0]  f_rtid [10];

      bus.data_req_i = 0; bus.data_type_i = 0; bus.data_paddr_i = 0;
      bus.data_wdata_i = 0; bus.data_be_i = 0; bus.data_tid_i = 0;
      bf.data_req_i = 0; bf.data_type_i = 0; bf.data_paddr_i = 0;
      bf.data_wdata_i = 0; bf.data_be_i = 0; bf.data_tid_i = 0;
      model_reset();

      // Reset state
      #2;
      chk_zero_out("reset");
      chk("reset_ack", bus.data_ack_o, 0);
      chk("reset_full_vld", bf.rtrn_vld_o, 0);
      @(posedge clk); @(posedge clk); #1;
      rst_n = 1'b1;

      // Directed table: latency, byte merge, address wrap, reserved type
      tbl.push_back(v(1, 2'd1, 64'd40, 0, 0, 2'd1, 1, 0, 0, 0, 0, 0));
      tbl.push_back(vi(0, 0, 0, 0, 1));
      tbl.push_back(vi(0, 0, 0, 0, 1));
      tbl.push_back(vi(1, 2'd1, 2'd1, 0, 1));
      tbl.push_back(vi(0, 0, 0, 0, 0));
      tbl.push_back(v(1, 2'd2, 64'd40, 64'h1122334455667788, 8'hFF, 2'd0, 1, 0, 0, 0, 0, 0));
      tbl.push_back(v(1, 2'd2, 64'd40, 64'hAA, 8'h01, 2'd2, 1, 0, 0, 0, 0, 1));
      tbl.push_back(v(1, 2'd1, 64'd40, 0, 0, 2'd3, 1, 0, 0, 0, 0, 1));
      tbl.push_back(vi(1, 2'd2, 2'd0, 0, 1));
      tbl.push_back(vi(1, 2'd2, 2'd2, 0, 1));
      tbl.push_back(vi(1, 2'd1, 2'd3, 64'h11223344556677AA, 1));
      tbl.push_back(vi(0, 0, 0, 0, 0));
      tbl.push_back(v(1, 2'd2, 64'd0, 64'hDEAD, 8'hFF, 2'd1, 1, 0, 0, 0, 0, 0));
      tbl.push_back(v(1, 2'd1, 64'd2048, 0, 0, 2'd2, 1, 0, 0, 0, 0, 1));
      tbl.push_back(vi(0, 0, 0, 0, 1));
      tbl.push_back(vi(1, 2'd2, 2'd1, 0, 1));
      tbl.push_back(vi(1, 2'd1, 2'd2, 64'hDEAD, 1));
      tbl.push_back(vi(0, 0, 0, 0, 0));
      for (int i = 0; i < 10; i++)
         tbl.push_back(v(1, 2'd3, 64'd40, 64'hFFFF, 8'hFF, 2'd3, 0, 0, 0, 0, 0, 0));
      tbl.push_back(v(1, 2'd1, 64'd40, 0, 0, 2'd0, 1, 0, 0, 0, 0, 0));
      tbl.push_back(vi(0, 0, 0, 0, 1));
      tbl.push_back(vi(0, 0, 0, 0, 1));
      tbl.push_back(vi(1, 2'd1, 2'd0, 64'h11223344556677AA, 1));
      tbl.push_back(vi(0, 0, 0, 0, 0));

      foreach (tbl[i]) begin
         step(tbl[i].req, tbl[i].typ, tbl[i].paddr, tbl[i].wdata, tbl[i].be, tbl[i].tid);
         chk($sformatf("tbl%0d_ack", i), a_ack, tbl[i].ack);
         chk($sformatf("tbl%0d_vld", i), a_vld, tbl[i].vld);
         chk($sformatf("tbl%0d_type", i), a_typ, tbl[i].rtyp);
         chk($sformatf("tbl%0d_tid", i), a_tid, tbl[i].rtid);
         chk($sformatf("tbl%0d_data", i), a_data, tbl[i].rdata);
         chk($sformatf("tbl%0d_busy", i), a_busy, tbl[i].busy);
      end

      // Random traffic over a small set of words, random upper address bits
      for (int i = 0; i < 400; i++) begin
         pa = {$urandom, $urandom};
         pa[10:3] = 8'($urandom_range(0, 7));
         wd = {$urandom, $urandom};
         step($urandom_range(0, 9) < 6, 2'($urandom_range(0, 2)), pa, wd,
              8'($urandom), 2'($urandom));
      end
      idle(8);
      chk("drain_empty", q.size(), 0);

      // Reset with requests in flight: nothing comes back, memory is cleared
      step(1, 2'd2, 64'd56, 64'h1234, 8'hFF, 2'd0);
      idle(3);
      step(1, 2'd1, 64'd56, 0, 0, 2'd1);
      step(1, 2'd1, 64'd56, 0, 0, 2'd2);
      step(1, 2'd1, 64'd56, 0, 0, 2'd3);
      chk("pre_rst_busy", bus.busy_o, 1);
      do_reset();
      idle(8);
      step(1, 2'd1, 64'd56, 0, 0, 2'd1);
      idle(2);
      step(0, 2'd0, 0, 0, 0, 2'd0);
      chk("post_rst_vld", a_vld, 1);
      chk("post_rst_data", a_data, 0);
      idle(2);

      // Full FIFO on the depth-2, latency-4 instance
      f_req  = '{1, 1, 1, 1, 1, 0, 0, 0, 0, 0};
      f_tid  = '{0, 1, 2, 2, 2, 0, 0, 0, 0, 0};
      f_ack  = '{1, 1, 0, 0, 1, 0, 0, 0, 0, 0};
      f_vld  = '{0, 0, 0, 0, 1, 1, 0, 0, 1, 0};
      f_rtid = '{0, 0, 0, 0, 0, 1, 0, 0, 2, 0};
      for (int k = 0; k < 10; k++) begin
         bf.data_req_i   = f_req[k];
         bf.data_type_i  = 2'd1;
         bf.data_paddr_i = 64'd8;
         bf.data_tid_i   = f_tid[k];
         @(negedge clk);
         chk($sformatf("full%0d_ack", k), bf.data_ack_o, f_ack[k]);
         chk($sformatf("full%0d_vld", k), bf.rtrn_vld_o, f_vld[k]);
         chk($sformatf("full%0d_tid", k), bf.rtrn_tid_o, f_rtid[k]);
         @(posedge clk);
         #1;
      end
      bf.data_req_i = 1'b0;

      $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
      $finish;
   end
endmodule
